// File: rtl/ysyx_25040105_lsu_if.sv
// Handshake bundles for the LSU: EXU/WBU-facing request/response channel and
// the word-wide memory bus channel.
interface ysyx_25040105_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface ysyx_25040105_lsu_mem_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;
    logic        mem_rsp_err;

    modport master (
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );
    modport slave (
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );
endinterface

// File: rtl/ysyx_25040105_lsu.sv
// Load/store unit: EXU request -> handshaked word bus -> formatted writeback.
// Optional bus timeout in WAIT enabled by defining YSYX_25040105_LSU_TIMEOUT_EN.
module ysyx_25040105_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    ysyx_25040105_lsu_if.slave              core,
    ysyx_25040105_lsu_mem_if.master         mem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        mem_req_valid_q, mem_req_valid_d;
    logic        mem_req_wen_q, mem_req_wen_d;
    logic [31:0] mem_req_addr_q, mem_req_addr_d;
    logic [31:0] mem_req_wdata_q, mem_req_wdata_d;
    logic [3:0]  mem_req_wstrb_q, mem_req_wstrb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

`ifdef YSYX_25040105_LSU_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    function automatic logic lsu_illegal(input logic wen, input logic [2:0] f3, input logic [1:0] o);
        logic bad_code;
        logic misal;
        if (wen) begin
            bad_code = (f3 > 3'd2);
        end else begin
            bad_code = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        case (f3[1:0])
            2'd1:    misal = o[0];
            2'd2:    misal = (o != 2'd0);
            default: misal = 1'b0;
        endcase
        return bad_code | misal;
    endfunction

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] o, input logic [2:0] f3);
        logic [31:0] sh;
        sh = w >> {o, 3'b000};
        case (f3)
            3'd0:    return {{24{sh[7]}}, sh[7:0]};
            3'd4:    return {24'h0, sh[7:0]};
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd5:    return {16'h0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    always_comb begin
        state_d         = state_q;
        req_ready_d     = req_ready_q;
        off_d           = off_q;
        f3_d            = f3_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_wen_d   = mem_req_wen_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        mem_req_wstrb_d = mem_req_wstrb_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_err_d       = rsp_err_q;
`ifdef YSYX_25040105_LSU_TIMEOUT_EN
        cnt_d           = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (core.req_valid) begin
                    off_d       = core.req_addr[1:0];
                    f3_d        = core.req_funct3;
                    req_ready_d = 1'b0;
                    if (lsu_illegal(core.req_wen, core.req_funct3, core.req_addr[1:0])) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d         = S_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_req_wen_d   = core.req_wen;
                        mem_req_addr_d  = {core.req_addr[31:2], 2'b00};
                        mem_req_wdata_d = '0;
                        mem_req_wstrb_d = '0;
                        // Loads never assert strobes; stores replicate data to every lane.
                        if (core.req_wen) begin
                            case (core.req_funct3[1:0])
                                2'd0: begin
                                    mem_req_wstrb_d = 4'b0001 << core.req_addr[1:0];
                                    mem_req_wdata_d = {4{core.req_wdata[7:0]}};
                                end
                                2'd1: begin
                                    mem_req_wstrb_d = core.req_addr[1] ? 4'b1100 : 4'b0011;
                                    mem_req_wdata_d = {2{core.req_wdata[15:0]}};
                                end
                                default: begin
                                    mem_req_wstrb_d = 4'b1111;
                                    mem_req_wdata_d = core.req_wdata;
                                end
                            endcase
                        end
                    end
                end
            end
            S_REQ: begin
                if (mem.mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = S_WAIT;
`ifdef YSYX_25040105_LSU_TIMEOUT_EN
                    cnt_d           = '0;
`endif
                end
            end
            S_WAIT: begin
                if (mem.mem_rsp_valid) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = mem.mem_rsp_err;
                    rsp_rdata_d = (mem_req_wen_q || mem.mem_rsp_err) ? '0
                                  : fmt_load(mem.mem_rsp_rdata, off_q, f3_q);
                end
`ifdef YSYX_25040105_LSU_TIMEOUT_EN
                else if (cnt_q >= TO_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (core.rsp_ready) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            req_ready_q     <= 1'b1;
            off_q           <= '0;
            f3_q            <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_wen_q   <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wdata_q <= '0;
            mem_req_wstrb_q <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_err_q       <= 1'b0;
`ifdef YSYX_25040105_LSU_TIMEOUT_EN
            cnt_q           <= '0;
`endif
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            off_q           <= off_d;
            f3_q            <= f3_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_wen_q   <= mem_req_wen_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            mem_req_wstrb_q <= mem_req_wstrb_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_err_q       <= rsp_err_d;
`ifdef YSYX_25040105_LSU_TIMEOUT_EN
            cnt_q           <= cnt_d;
`endif
        end
    end

    assign core.req_ready     = req_ready_q;
    assign core.rsp_valid     = rsp_valid_q;
    assign core.rsp_rdata     = rsp_rdata_q;
    assign core.rsp_err       = rsp_err_q;
    assign mem.mem_req_valid  = mem_req_valid_q;
    assign mem.mem_req_wen    = mem_req_wen_q;
    assign mem.mem_req_addr   = mem_req_addr_q;
    assign mem.mem_req_wdata  = mem_req_wdata_q;
    assign mem.mem_req_wstrb  = mem_req_wstrb_q;

endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// Self-checking bench for ysyx_25040105_lsu: directed plan vectors plus
// randomized transactions against a size/offset arithmetic reference model.
module tb_ysyx_25040105_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_25040105_lsu_if     core_if ();
    ysyx_25040105_lsu_mem_if mem_if ();

    ysyx_25040105_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .core (core_if),
        .mem  (mem_if)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] got_rdata;
    logic        got_err;
    int unsigned got_lat;
    logic [31:0] got_maddr;
    logic [31:0] got_mwdata;
    logic [3:0]  got_mstrb;

    task automatic idle_inputs();
        core_if.req_valid      = 1'b0;
        core_if.req_wen        = 1'b0;
        core_if.req_addr       = '0;
        core_if.req_wdata      = '0;
        core_if.req_funct3     = '0;
        core_if.rsp_ready      = 1'b0;
        mem_if.mem_req_ready   = 1'b0;
        mem_if.mem_rsp_valid   = 1'b0;
        mem_if.mem_rsp_rdata   = '0;
        mem_if.mem_rsp_err     = 1'b0;
    endtask

    // One complete transaction with a cycle-by-cycle bus/writeback responder.
    task automatic run_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word, input logic berr,
                           input int unsigned req_wait, input int unsigned rsp_delay,
                           input int unsigned rsp_wait);
        int unsigned o, nb, e, mreq_n, wait_n, rsp_n;
        logic legal, illegal, e_err, in_wait, responded, hs_req, hs_rsp, rsp_seen, done;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic [3:0] e_strb;
        longint unsigned v, lim;

        o       = 32'(addr[1:0]);
        nb      = 32'd1 << f3[1:0];
        legal   = wen ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        illegal = !legal || ((o % nb) != 0);
        e_addr  = addr & 32'hFFFF_FFFC;
        e_strb  = 4'(((32'd1 << nb) - 32'd1) << o);
        if (nb == 1)      e_wdata = (wdata & 32'h0000_00FF) * 32'h0101_0101;
        else if (nb == 2) e_wdata = (wdata & 32'h0000_FFFF) * 32'h0001_0001;
        else              e_wdata = wdata;
        v   = longint'(word) >> (8 * o);
        lim = 64'd1 << (8 * nb);
        v   = v % lim;
        if (f3 < 3'd4 && nb < 4 && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
        e_rdata = (wen || berr || illegal) ? 32'h0 : v[31:0];
        e_err   = illegal || berr;

        n_checks++;
        if (core_if.req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL req_ready_before_accept: got %b want 1", core_if.req_ready);
        end
        core_if.req_valid  = 1'b1;
        core_if.req_wen    = wen;
        core_if.req_addr   = addr;
        core_if.req_wdata  = wdata;
        core_if.req_funct3 = f3;
        @(posedge clk); #1;
        core_if.req_valid  = 1'b0;
        core_if.req_wen    = 1'($urandom);
        core_if.req_addr   = $urandom;
        core_if.req_wdata  = $urandom;
        core_if.req_funct3 = 3'($urandom);

        e = 0; mreq_n = 0; wait_n = 0; rsp_n = 0; got_lat = 999;
        in_wait = 0; responded = 0; hs_rsp = 0; rsp_seen = 0; done = 0;
        while (!done && e < 300) begin
            if (hs_rsp) begin
                n_checks++;
                if (core_if.rsp_valid !== 1'b0 || core_if.req_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL after_rsp_handshake: rsp_valid=%b req_ready=%b want 0/1",
                             core_if.rsp_valid, core_if.req_ready);
                end
                done = 1;
            end else begin
                hs_req = 0;
                if (mem_if.mem_req_valid === 1'b1) begin
                    mreq_n++;
                    got_maddr = mem_if.mem_req_addr;
                    got_mwdata = mem_if.mem_req_wdata;
                    got_mstrb = mem_if.mem_req_wstrb;
                    n_checks++;
                    if (illegal || mem_if.mem_req_addr !== e_addr || mem_if.mem_req_wen !== wen ||
                        mem_if.mem_req_wstrb !== (wen ? e_strb : 4'b0000) ||
                        (wen && mem_if.mem_req_wdata !== e_wdata)) begin
                        n_errors++;
                        $display("FAIL mem_req_fields: addr=%h wen=%b strb=%b wdata=%h want addr=%h wen=%b strb=%b wdata=%h illegal=%b",
                                 mem_if.mem_req_addr, mem_if.mem_req_wen, mem_if.mem_req_wstrb,
                                 mem_if.mem_req_wdata, e_addr, wen, wen ? e_strb : 4'b0000, e_wdata, illegal);
                    end
                    mem_if.mem_req_ready = (mreq_n > req_wait);
                    hs_req = mem_if.mem_req_ready;
                end else begin
                    mem_if.mem_req_ready = 1'($urandom);
                end
                if (in_wait && !responded && wait_n >= rsp_delay) begin
                    mem_if.mem_rsp_valid = 1'b1;
                    mem_if.mem_rsp_rdata = word;
                    mem_if.mem_rsp_err   = berr;
                    responded = 1;
                end else if (in_wait && !responded) begin
                    mem_if.mem_rsp_valid = 1'b0;
                    mem_if.mem_rsp_rdata = $urandom;
                    wait_n++;
                end else begin
                    mem_if.mem_rsp_valid = 1'($urandom);
                    mem_if.mem_rsp_rdata = $urandom;
                    mem_if.mem_rsp_err   = 1'($urandom);
                end
                in_wait = in_wait || hs_req;
                if (core_if.rsp_valid === 1'b1) begin
                    if (!rsp_seen) begin
                        rsp_seen  = 1;
                        got_lat   = e;
                        got_rdata = core_if.rsp_rdata;
                        got_err   = core_if.rsp_err;
                    end
                    rsp_n++;
                    n_checks++;
                    if (core_if.rsp_rdata !== e_rdata || core_if.rsp_err !== e_err) begin
                        n_errors++;
                        $display("FAIL rsp_fields: rdata=%h err=%b want rdata=%h err=%b (f3=%0d wen=%b addr=%h)",
                                 core_if.rsp_rdata, core_if.rsp_err, e_rdata, e_err, f3, wen, addr);
                    end
                    core_if.rsp_ready = (rsp_n > rsp_wait);
                    hs_rsp = core_if.rsp_ready;
                end else begin
                    if (rsp_seen) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rsp_dropped: rsp_valid=0 before handshake, want 1");
                    end
                    core_if.rsp_ready = 1'($urandom);
                end
                @(posedge clk); #1;
                e++;
            end
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL txn_timeout: no completion within 300 cycles, want completion");
        end
        n_checks++;
        if ((illegal && mreq_n != 0) || (!illegal && mreq_n != req_wait + 1)) begin
            n_errors++;
            $display("FAIL mem_req_cycles: got %0d want %0d", mreq_n, illegal ? 0 : req_wait + 1);
        end
        if (req_wait == 0 && rsp_delay == 0) begin
            n_checks++;
            if (got_lat != (illegal ? 0 : 2)) begin
                n_errors++;
                $display("FAIL latency: got %0d edges after accept want %0d", got_lat, illegal ? 0 : 2);
            end
        end
        idle_inputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (core_if.req_ready !== 1'b1 || core_if.rsp_valid !== 1'b0 || core_if.rsp_rdata !== 32'h0 ||
            core_if.rsp_err !== 1'b0 || mem_if.mem_req_valid !== 1'b0 || mem_if.mem_req_wen !== 1'b0 ||
            mem_if.mem_req_addr !== 32'h0 || mem_if.mem_req_wdata !== 32'h0 || mem_if.mem_req_wstrb !== 4'h0) begin
            n_errors++;
            $display("FAIL %s: req_ready=%b rsp_valid=%b rdata=%h err=%b mvalid=%b mwen=%b maddr=%h mwdata=%h mstrb=%b want 1/0/0/0/0/0/0/0/0",
                     tag, core_if.req_ready, core_if.rsp_valid, core_if.rsp_rdata, core_if.rsp_err,
                     mem_if.mem_req_valid, mem_if.mem_req_wen, mem_if.mem_req_addr,
                     mem_if.mem_req_wdata, mem_if.mem_req_wstrb);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        #3 rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("idle_after_reset");
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] rdata, input logic err);
        n_checks++;
        if (got_rdata !== rdata || got_err !== err) begin
            n_errors++;
            $display("FAIL %s: rdata=%h err=%b want rdata=%h err=%b", tag, got_rdata, got_err, rdata, err);
        end
    endtask

    task automatic test_directed();
        run_txn(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 1'b0, 0, 0, 0);
        expect_rsp("lb_sign", 32'hFFFF_FF80, 1'b0);
        run_txn(1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'hBEEF_0011, 1'b0, 0, 0, 0);
        expect_rsp("lhu_zero", 32'h0000_BEEF, 1'b0);
        run_txn(1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'hBEEF_0011, 1'b0, 0, 0, 0);
        expect_rsp("lh_sign", 32'hFFFF_BEEF, 1'b0);
        run_txn(1'b1, 3'd0, 32'h8000_0001, 32'h1234_56AB, 32'hDEAD_BEEF, 1'b0, 0, 0, 0);
        expect_rsp("sb_rsp", 32'h0, 1'b0);
        n_checks++;
        if (got_mstrb !== 4'b0010 || got_mwdata !== 32'hABAB_ABAB || got_maddr !== 32'h8000_0000) begin
            n_errors++;
            $display("FAIL sb_bus: strb=%b wdata=%h addr=%h want 0010 ababab ab 80000000",
                     got_mstrb, got_mwdata, got_maddr);
        end
        run_txn(1'b0, 3'd2, 32'h8000_0002, 32'h0, 32'h1111_2222, 1'b0, 0, 0, 0);
        expect_rsp("lw_misaligned", 32'h0, 1'b1);
        run_txn(1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h1111_2222, 1'b0, 0, 0, 0);
        expect_rsp("load_f3_3", 32'h0, 1'b1);
        run_txn(1'b0, 3'd2, 32'h8000_0004, 32'h0, 32'h1111_2222, 1'b1, 0, 0, 0);
        expect_rsp("bus_error", 32'h0, 1'b1);
    endtask

    task automatic test_stall();
        run_txn(1'b1, 3'd2, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 1'b0, 5, 1, 3);
        expect_rsp("stall_store", 32'h0, 1'b0);
        core_if.rsp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (core_if.rsp_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL single_completion: rsp_valid=%b want 0", core_if.rsp_valid);
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 200; i++) begin
            run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    ($urandom_range(7) == 0), $urandom_range(3), $urandom_range(3), $urandom_range(2));
        end
    endtask

    task automatic test_reset_mid();
        core_if.req_valid  = 1'b1;
        core_if.req_wen    = 1'b0;
        core_if.req_addr   = 32'h8000_0010;
        core_if.req_funct3 = 3'd2;
        @(posedge clk); #1;
        core_if.req_valid = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_if.mem_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_in_wait");
        #2 rst = 1'b1;
        mem_if.mem_rsp_valid = 1'b1;
        mem_if.mem_rsp_rdata = 32'h1234_5678;
        repeat (4) begin
            @(posedge clk); #1;
            n_checks++;
            if (core_if.rsp_valid !== 1'b0 || core_if.req_ready !== 1'b1 || mem_if.mem_req_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL stale_rsp_after_reset: rsp_valid=%b req_ready=%b mvalid=%b want 0/1/0",
                         core_if.rsp_valid, core_if.req_ready, mem_if.mem_req_valid);
            end
        end
        idle_inputs();
    endtask

`ifdef YSYX_25040105_LSU_TIMEOUT_EN
    task automatic test_timeout();
        int unsigned n;
        core_if.req_valid  = 1'b1;
        core_if.req_wen    = 1'b0;
        core_if.req_addr   = 32'h8000_0020;
        core_if.req_funct3 = 3'd2;
        @(posedge clk); #1;
        core_if.req_valid = 1'b0;
        mem_if.mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_if.mem_req_ready = 1'b0;
        n = 0;
        while (core_if.rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (n != 4 || core_if.rsp_err !== 1'b1 || core_if.rsp_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL timeout: wait_cycles=%0d err=%b rdata=%h want 4/1/0", n, core_if.rsp_err, core_if.rsp_rdata);
        end
        mem_if.mem_rsp_valid = 1'b1;
        core_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        core_if.rsp_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (core_if.rsp_valid !== 1'b0 || core_if.req_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL late_rsp_ignored: rsp_valid=%b req_ready=%b want 0/1",
                         core_if.rsp_valid, core_if.req_ready);
            end
        end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef YSYX_25040105_LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
